// File: rtl/fb_arb_pkg.sv
// Shared constants, state encoding and helpers for the frame-buffer port arbiter.
// Optional statistics counter is enabled by defining FB_ARB_STATS_EN.
package fb_arb_pkg;

  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 16;
  localparam int FRAME_W      = 640;
  localparam int FRAME_H      = 480;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int FIFO_DEPTH   = 512;

  // Capture sequencer states; the encoding is visible on the state port.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_HOLD     = 2'd3
  } arb_state_e;

  // Saturating add of a small increment to a 16-bit counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] cur, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cur} + {15'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/fb_arb_fifo.sv
// Synchronous single-clock FIFO with head peek; holds {sof, pixel} camera entries.
// Push is ignored when full and pop is ignored when empty.
module fb_arb_fifo #(
  parameter int WIDTH = fb_arb_pkg::DATA_W + 1,
  parameter int DEPTH = fb_arb_pkg::FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  import fb_arb_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointer values.
  always_comb begin
    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; emptying the pointers is enough and keeps it mappable to RAM.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: display reads have absolute priority on the single BRAM
// port; camera pixels are buffered in a FIFO and written back-to-back while the
// capture sequencer is in CAPTURE. Define FB_ARB_STATS_EN to get a saturating
// count of lost and discarded pixels on drop_count; otherwise it is tied to zero.
module fb_port_arbiter #(
  parameter int ADDR_W       = fb_arb_pkg::ADDR_W,
  parameter int DATA_W       = fb_arb_pkg::DATA_W,
  parameter int FIFO_DEPTH   = fb_arb_pkg::FIFO_DEPTH,
  parameter int FRAME_PIXELS = fb_arb_pkg::FRAME_PIXELS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              cam_valid,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              cam_sof,
  output logic              cam_ready,
  input  logic              capture_enable,
  input  logic              single_shot,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state,
  output logic [7:0]        frame_count,
  output logic              frame_done,
  output logic              overflow,
  output logic              err_short,
  output logic [15:0]       drop_count
);
  import fb_arb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef struct packed {
    logic              sof;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  fifo_entry_t       fifo_head;
  logic [DATA_W:0]   fifo_head_raw;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              pix_lost, wr_cycle, discard;
  logic [ADDR_W-1:0] wr_addr;

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic              err_short_q, err_short_d;

  fb_arb_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({cam_sof, cam_data}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head_raw)
  );

  assign fifo_head = fifo_head_raw;

  // The camera cannot be stalled: a pixel offered while full is simply lost.
  assign cam_ready = !fifo_full && !reset;
  assign fifo_push = cam_valid && cam_ready;
  assign pix_lost  = cam_valid && fifo_full && !reset;

  // A write only happens when the display leaves the port free.
  assign wr_cycle  = !reset && !rd_en && (state_q == ST_CAPTURE) && !fifo_empty;
  // A start-of-frame pixel always lands at address 0, restarting a short frame.
  assign wr_addr   = fifo_head.sof ? '0 : wr_ptr_q;
  assign fifo_pop  = wr_cycle || discard;

  assign rd_data   = mem_rdata;

  // Single-port mux: display read, else pending camera write, else idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = fifo_head.data;
    if (!reset) begin
      if (rd_en) begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end else if (wr_cycle) begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = wr_addr;
      end
    end
  end

  // Capture sequencer next-state, write pointer and frame bookkeeping.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    overflow_d    = overflow_q | pix_lost;
    err_short_d   = err_short_q;
    discard       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        discard = !fifo_empty;
        if (capture_enable) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        // The SOF entry itself stays in the FIFO and becomes the first write.
        discard = !fifo_empty && !fifo_head.sof;
        if (!capture_enable) begin
          state_d = ST_IDLE;
        end else if (!fifo_empty && fifo_head.sof) begin
          wr_ptr_d = '0;
          state_d  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (wr_cycle) begin
          wr_ptr_d = wr_addr + ADDR_ONE;
          if (fifo_head.sof && (wr_ptr_q != '0)) err_short_d = 1'b1;
          if (wr_addr == LAST_ADDR) begin
            // Completion wins over a simultaneous capture_enable drop.
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
            wr_ptr_d      = '0;
            if (single_shot)          state_d = ST_HOLD;
            else if (!capture_enable) state_d = ST_IDLE;
            else                      state_d = ST_WAIT_SOF;
          end else if (!capture_enable) begin
            state_d = ST_IDLE;
          end
        end else if (!capture_enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        discard = !fifo_empty;
        if (!capture_enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      err_short_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      err_short_q   <= err_short_d;
    end
  end

  assign state       = state_q;
  assign frame_count = frame_count_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign err_short   = err_short_q;

`ifdef FB_ARB_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;

  // Lost and discarded pixels can coincide, so the step can be two.
  always_comb begin
    drop_count_d = sat_inc16(drop_count_q, {1'b0, pix_lost} + {1'b0, discard});
  end

  // Drop counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) drop_count_q <= '0;
    else       drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a small frame size so whole frames fit
// in a short run. Expected BRAM writes are queued as pixels are driven and
// popped when the DUT issues a write.
module tb_fb_port_arbiter;
  import fb_arb_pkg::*;

  localparam int TB_FP = 1024;
`ifdef FB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk, reset;
  logic        rd_en;
  logic [18:0] rd_addr;
  logic [15:0] rd_data;
  logic        cam_valid, cam_sof, cam_ready;
  logic [15:0] cam_data;
  logic        capture_enable, single_shot;
  logic        mem_en, mem_we;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  state;
  logic [7:0]  frame_count;
  logic        frame_done, overflow, err_short;
  logic [15:0] drop_count;

  typedef struct packed {
    logic [18:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          base_done, base_wr;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_exp = '0;
  logic [15:0] bram [0:1023];

  fb_port_arbiter #(.FRAME_PIXELS(TB_FP)) dut (
    .clk            (clk),
    .reset          (reset),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .cam_valid      (cam_valid),
    .cam_data       (cam_data),
    .cam_sof        (cam_sof),
    .cam_ready      (cam_ready),
    .capture_enable (capture_enable),
    .single_shot    (single_shot),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .state          (state),
    .frame_count    (frame_count),
    .frame_done     (frame_done),
    .overflow       (overflow),
    .err_short      (err_short),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial mem_rdata = '0;

  // BRAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: port mux on reads, read latency, write scoreboard, done pulses.
  always @(negedge clk) begin
    if (rd_pend) chk("rd_data", {16'b0, rd_data}, {16'b0, rd_exp});
    rd_pend = rd_en && !reset;
    if (rd_pend) begin
      rd_exp = bram[rd_addr[9:0]];
      chk("rd_port_en_we", {30'b0, mem_en, mem_we}, 32'd2);
      chk("rd_port_addr", {13'b0, mem_addr}, {13'b0, rd_addr});
    end
    if (mem_en && mem_we) begin
      wr_cnt++;
      chk("wr_expected", {31'b0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        wr_t e;
        e = sbq.pop_front();
        chk("wr_addr", {13'b0, mem_addr}, {13'b0, e.addr});
        chk("wr_data", {16'b0, mem_wdata}, {16'b0, e.data});
      end
    end
    if (frame_done) done_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push_pix(input logic [15:0] d, input logic s, input logic expect_wr, input logic [18:0] a);
    cam_valid = 1'b1;
    cam_data  = d;
    cam_sof   = s;
    if (expect_wr) sbq.push_back(wr_t'{addr: a, data: d});
    tick();
    cam_valid = 1'b0;
    cam_sof   = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (sbq.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_pending", sbq.size(), 0);
  endtask

  initial begin
    reset = 1'b1; rd_en = 1'b1; rd_addr = 19'd5;
    cam_valid = 1'b0; cam_data = '0; cam_sof = 1'b0;
    capture_enable = 1'b0; single_shot = 1'b0;

    // Reset values, with a read request held to prove the port stays off.
    repeat (3) tick();
    at_neg();
    chk("rst_state", state, ST_IDLE);
    chk("rst_cam_ready", cam_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_err_short", err_short, 0);
    chk("rst_drop_count", drop_count, 0);
    rd_en = 1'b0; reset = 1'b0;
    tick(); at_neg();
    chk("post_rst_cam_ready", cam_ready, 1);

    // One full frame, SOF on the first pixel.
    capture_enable = 1'b1;
    tick(); at_neg();
    chk("t2_wait_sof", state, ST_WAIT_SOF);
    base_done = done_cnt;
    for (int i = 0; i < TB_FP; i++) push_pix(16'(16'h1000 + i), i == 0, 1'b1, 19'(i));
    wait_drain(200);
    tick(); tick(); at_neg();
    chk("t2_frame_count", frame_count, 1);
    chk("t2_done_pulses", done_cnt - base_done, 1);
    chk("t2_state", state, ST_WAIT_SOF);
    chk("t2_err_short", err_short, 0);

    // Display burst of 640 reads while the camera delivers 320 pixels.
    tick();
    base_wr = wr_cnt;
    for (int i = 0; i < 640; i++) begin
      rd_en   = 1'b1;
      rd_addr = 19'(i);
      if (i % 2 == 0) begin
        cam_valid = 1'b1;
        cam_sof   = (i == 0);
        cam_data  = 16'(16'h2000 + i / 2);
        sbq.push_back(wr_t'{addr: 19'(i / 2), data: 16'(16'h2000 + i / 2)});
      end else begin
        cam_valid = 1'b0;
        cam_sof   = 1'b0;
      end
      tick();
    end
    rd_en = 1'b0; cam_valid = 1'b0; cam_sof = 1'b0;
    chk("t3_burst_writes", wr_cnt - base_wr, 0);
    repeat (160) tick();
    chk("t3_blank_writes", wr_cnt - base_wr, 160);
    wait_drain(400);
    at_neg();
    chk("t3_overflow", overflow, 0);
    capture_enable = 1'b0;
    tick(); tick(); at_neg();
    chk("t3_idle", state, ST_IDLE);
    chk("t3_partial_not_counted", frame_count, 1);

    // Fill the FIFO behind a held read, then offer one more pixel.
    capture_enable = 1'b1; rd_en = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) begin
      rd_addr = 19'(900 + i % 100);
      push_pix(16'(16'h3000 + i), i == 0, 1'b1, 19'(i));
    end
    at_neg();
    chk("t4_full_ready", cam_ready, 0);
    chk("t4_no_overflow_yet", overflow, 0);
    chk("t4_capture", state, ST_CAPTURE);
    push_pix(16'hDEAD, 1'b0, 1'b0, 19'd0);
    at_neg();
    chk("t4_overflow", overflow, 1);
    chk("t4_drop_count", drop_count, STATS ? 32'd1 : 32'd0);
    rd_en = 1'b0;
    wait_drain(700);
    at_neg();
    chk("t4_ready_after_drain", cam_ready, 1);
    capture_enable = 1'b0;
    tick(); tick(); at_neg();
    chk("t4_idle", state, ST_IDLE);
    chk("t4_frame_count", frame_count, 1);

    // Early SOF at pixel 1000 restarts the frame at address 0.
    capture_enable = 1'b1;
    tick();
    for (int i = 0; i < 1000; i++) push_pix(16'(16'h4000 + i), i == 0, 1'b1, 19'(i));
    wait_drain(200);
    at_neg();
    chk("t5_err_short_before", err_short, 0);
    push_pix(16'h5000, 1'b1, 1'b1, 19'd0);
    for (int j = 1; j < TB_FP - 1; j++) push_pix(16'(16'h5000 + j), 1'b0, 1'b1, 19'(j));
    wait_drain(200);
    tick(); at_neg();
    chk("t5_err_short", err_short, 1);
    chk("t5_count_one_short", frame_count, 1);
    chk("t5_still_capture", state, ST_CAPTURE);
    base_done = done_cnt;
    push_pix(16'(16'h5000 + TB_FP - 1), 1'b0, 1'b1, 19'(TB_FP - 1));
    wait_drain(50);
    tick(); tick(); at_neg();
    chk("t5_frame_count", frame_count, 2);
    chk("t5_done_pulses", done_cnt - base_done, 1);
    chk("t5_wait_sof", state, ST_WAIT_SOF);

    // Single shot: two frames streamed, only the first is written.
    single_shot = 1'b1;
    tick();
    base_done = done_cnt; base_wr = wr_cnt;
    for (int i = 0; i < TB_FP; i++) push_pix(16'(16'h6000 + i), i == 0, 1'b1, 19'(i));
    for (int i = 0; i < TB_FP; i++) push_pix(16'(16'h7000 + i), i == 0, 1'b0, 19'd0);
    repeat (5) tick();
    at_neg();
    chk("t6_hold", state, ST_HOLD);
    chk("t6_frame_count", frame_count, 3);
    chk("t6_done_pulses", done_cnt - base_done, 1);
    chk("t6_writes", wr_cnt - base_wr, TB_FP);
    chk("t6_sb_empty", sbq.size(), 0);
    chk("t6_drop_count", drop_count, STATS ? 32'(TB_FP + 1) : 32'd0);
    capture_enable = 1'b0;
    tick(); tick(); at_neg();
    chk("t6_idle", state, ST_IDLE);
    single_shot = 1'b0;

    // Reset in the middle of a capture with entries still queued.
    capture_enable = 1'b1;
    tick();
    for (int i = 0; i < 500; i++) push_pix(16'(16'h8000 + i), i == 0, 1'b1, 19'(i));
    wait_drain(100);
    rd_en = 1'b1; rd_addr = 19'd900;
    for (int i = 0; i < 10; i++) push_pix(16'(16'h9000 + i), 1'b1, 1'b0, 19'd0);
    reset = 1'b1; rd_en = 1'b0;
    tick(); at_neg();
    chk("t7_state", state, ST_IDLE);
    chk("t7_frame_count", frame_count, 0);
    chk("t7_frame_done", frame_done, 0);
    chk("t7_overflow", overflow, 0);
    chk("t7_err_short", err_short, 0);
    chk("t7_drop_count", drop_count, 0);
    chk("t7_cam_ready", cam_ready, 0);
    chk("t7_mem_en", mem_en, 0);
    base_wr = wr_cnt;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("t7_fifo_flushed", wr_cnt - base_wr, 0);
    at_neg();
    chk("t7_wait_sof", state, ST_WAIT_SOF);
    chk("t7_ready", cam_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
